// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int GNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  // Advance an index by one, wrapping at n.
  function automatic logic [GNT_W-1:0] wrap_inc(input logic [GNT_W-1:0] idx, input logic [GNT_W-1:0] last);
    return (idx == last) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GNT_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [GNT_W-1:0] idx,
  output logic             any
);

  localparam logic [GNT_W:0] N_L = (GNT_W+1)'(NREQ);

  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   rot;
  logic [GNT_W:0]    sum     [NREQ];
  logic [GNT_W-1:0]  abs_idx [NREQ];

  // Rotate so that bit k of rot is request (ptr+k) mod NREQ.
  assign req2 = {req, req} >> ptr;
  assign rot  = req2[NREQ-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_off
      assign sum[gi]     = {1'b0, ptr} + (GNT_W+1)'(gi);
      assign abs_idx[gi] = (sum[gi] >= N_L) ? GNT_W'(sum[gi] - N_L) : GNT_W'(sum[gi]);
      assign gnt[gi]     = any && (idx == GNT_W'(gi));
    end
  endgenerate

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = abs_idx[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx byte transmitter between NREQ requesters,
// with an optional per-requester lock for uninterleaved multi-byte messages.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LOCK_TO = 1024,
  parameter int TOW     = 11
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   tx_ready,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_we,
  output logic                   busy,
  output logic [GNT_W-1:0]       gnt_id
);

  localparam logic [GNT_W-1:0] LAST_IDX = GNT_W'(NREQ - 1);
  localparam logic [TOW-1:0]   TO_LAST  = TOW'(LOCK_TO - 1);

  arb_state_t         state_reg;
  logic [BYTE_W-1:0]  tx_data_reg;
  logic               tx_we_reg;
  logic [GNT_W-1:0]   gnt_id_reg;
  logic [GNT_W-1:0]   rr_ptr_reg;
  logic               lock_held_reg;
  logic [GNT_W-1:0]   lock_owner_reg;
  logic [TOW-1:0]     to_cnt_reg;

  logic [BYTE_W-1:0]  req_byte [NREQ];
  logic [NREQ-1:0]    owner_onehot;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    win_gnt;
  logic [GNT_W-1:0]   win_idx;
  logic               win_any;
  logic [BYTE_W-1:0]  win_byte;
  logic               accept;
  logic               owner_valid;
  logic               to_run;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_byte[gi]     = req_data[BYTE_W*gi +: BYTE_W];
      assign owner_onehot[gi] = (lock_owner_reg == GNT_W'(gi));
    end
  endgenerate

  // While a lock is held only the owner may compete.
  assign eligible = lock_held_reg ? (req_valid & owner_onehot) : req_valid;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (eligible),
    .ptr (rr_ptr_reg),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      win_byte = win_byte | ({BYTE_W{win_gnt[k]}} & req_byte[k]);
    end
  end

  assign accept      = RST_X && (state_reg == IDLE) && tx_ready && win_any;
  assign req_ready   = accept ? win_gnt : '0;
  assign owner_valid = |(req_valid & owner_onehot);
  // An idle owner only burns down the lock while the arbiter is otherwise free.
  assign to_run      = (state_reg == IDLE) && lock_held_reg && !owner_valid;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_reg      <= IDLE;
      tx_data_reg    <= '0;
      tx_we_reg      <= 1'b0;
      gnt_id_reg     <= '0;
      rr_ptr_reg     <= '0;
      lock_held_reg  <= 1'b0;
      lock_owner_reg <= '0;
      to_cnt_reg     <= '0;
    end else begin
      tx_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tx_data_reg    <= win_byte;
            tx_we_reg      <= 1'b1;
            gnt_id_reg     <= win_idx;
            rr_ptr_reg     <= wrap_inc(win_idx, LAST_IDX);
            lock_held_reg  <= |(req_lock & win_gnt);
            lock_owner_reg <= win_idx;
            state_reg      <= ISSUE;
          end
        end
        ISSUE:   state_reg <= SETTLE;
        // UartTx only drops READY the cycle after WE, so READY is not trusted here.
        SETTLE:  state_reg <= DRAIN;
        DRAIN:   if (tx_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (to_run) begin
        if (to_cnt_reg == TO_LAST) begin
          lock_held_reg <= 1'b0;
          to_cnt_reg    <= '0;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  assign tx_data = tx_data_reg;
  assign tx_we   = tx_we_reg;
  assign gnt_id  = gnt_id_reg;
  assign busy    = (state_reg != IDLE) || lock_held_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UartTx READY model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] id;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_x = 1'b0;
  logic [NREQ-1:0]  req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]  req_lock = '0;
  logic [NREQ-1:0]  req_ready;
  logic             tx_ready = 1'b1;
  logic [7:0]       tx_data;
  logic             tx_we;
  logic             busy;
  logic [2:0]       gnt_id;

  exp_t       sb [$];
  logic [8:0] rq [NREQ][$];
  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int model_busy = 10;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TO(1024), .TOW(11)) dut (
    .CLK       (clk),
    .RST_X     (rst_x),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .busy      (busy),
    .gnt_id    (gnt_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int i, input logic lock, input logic [7:0] data);
    rq[i].push_back({lock, data});
  endtask

  task automatic expect_byte(input logic [7:0] data, input logic [2:0] id);
    sb.push_back({data, id});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (sb.size() == 0) && !busy && tx_ready && (req_valid == '0);
    end
    check({name, " completes"}, 32'(done), 32'd1);
  endtask

  // Monitor: one line per transmitted byte, compared against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_x && tx_we) begin
        we_count++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected tx_we: data %02h gnt_id %0d, nothing expected", tx_data, gnt_id);
        end else begin
          e = sb.pop_front();
          $display("tx byte %02h from req %0d (expected %02h from req %0d)", tx_data, gnt_id, e.data, e.id);
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("gnt_id", 32'(gnt_id), 32'(e.id));
          check("tx_ready at tx_we", 32'(tx_ready), 32'd1);
        end
      end
    end
  end

  // UartTx model: READY drops the cycle after WE and stays low model_busy cycles.
  initial begin : uart_model
    forever begin
      @(negedge clk);
      if (rst_x && tx_we) begin
        @(posedge clk);
        #1 tx_ready = 1'b0;
        for (int k = 0; k < model_busy; k++) begin
          @(posedge clk);
          if (!rst_x) break;
        end
        #1 tx_ready = 1'b1;
      end
    end
  end

  // Requester drivers: present queued bytes, retire them on handshake.
  initial begin : driver
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          void'(rq[i].pop_front());
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && rq[i].size() > 0) begin
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_lock[i]        = rq[i][0][8];
          req_valid[i]       = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_x = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_x = 1'b1;
  endtask

  initial begin : stimulus
    int n;
    int viol;
    int base;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_we", 32'(tx_we), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset gnt_id", 32'(gnt_id), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst_x = 1'b1;

    // Single requester
    model_busy = 10;
    send(1, 1'b0, 8'h61);
    expect_byte(8'h61, 3'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_valid[1] && n < 10);
    check("single req_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check("single gnt_id", 32'(gnt_id), 32'd1);
    check("single busy in ISSUE", 32'(busy), 32'd1);
    check("single req_ready in ISSUE", 32'(req_ready), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_ready && n < 50);
    check("single busy while draining", 32'(busy), 32'd1);
    @(negedge clk);
    check("single busy after drain", 32'(busy), 32'd0);
    wait_done("single", 50);

    // All four valid, slow UartTx
    do_reset();
    model_busy = 100;
    base = we_count;
    for (int i = 0; i < NREQ; i++) begin
      send(i, 1'b0, 8'h30 + 8'(i));
      expect_byte(8'h30 + 8'(i), 3'(i));
    end
    wait_done("all four", 2000);
    check("all four tx_we count", 32'(we_count - base), 32'd4);

    // Lock: req 2 sends H,i while req 0 waits with x
    model_busy = 10;
    base = we_count;
    send(2, 1'b1, 8'h48);
    send(2, 1'b0, 8'h69);
    expect_byte(8'h48, 3'd2);
    expect_byte(8'h69, 3'd2);
    expect_byte(8'h78, 3'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[2] && n < 20);
    send(0, 1'b0, 8'h78);
    viol = 0;
    n = 0;
    seen = 0;
    while (we_count < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (req_valid[0]) seen = 1;
      if (req_ready[0]) viol++;
    end
    check("lock req0 waited valid", 32'(seen), 32'd1);
    check("lock req_ready[0] during lock", 32'(viol), 32'd0);
    wait_done("lock", 200);

    // Lock timeout: req 3 locks then leaves; req 1 waits out LOCK_TO idle cycles
    send(3, 1'b1, 8'h55);
    expect_byte(8'h55, 3'd3);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_we && n < 20);
    send(1, 1'b0, 8'h77);
    expect_byte(8'h77, 3'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_ready && n < 50);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[1] && n < 1200);
    check("timeout grant cycle after drain", 32'(n), 32'd1025);
    check("timeout req_ready", 32'(req_ready), 32'b0010);
    wait_done("timeout", 200);

    // Pointer wrap: grant 3, then 0 and 2 both valid
    send(3, 1'b0, 8'hD3);
    expect_byte(8'hD3, 3'd3);
    wait_done("wrap first", 200);
    send(0, 1'b0, 8'hA0);
    send(2, 1'b0, 8'hA2);
    expect_byte(8'hA0, 3'd0);
    expect_byte(8'hA2, 3'd2);
    wait_done("wrap", 300);

    // Reset mid-DRAIN; afterwards pointer back at 0
    send(2, 1'b0, 8'hEE);
    expect_byte(8'hEE, 3'd2);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_we && n < 20);
    repeat (3) @(negedge clk);
    check("pre-reset gnt_id", 32'(gnt_id), 32'd2);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_x = 1'b0;
    #1;
    check("async reset tx_we", 32'(tx_we), 32'd0);
    check("async reset tx_data", 32'(tx_data), 32'd0);
    check("async reset gnt_id", 32'(gnt_id), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_x = 1'b1;
    send(3, 1'b0, 8'hB3);
    send(0, 1'b0, 8'hB0);
    expect_byte(8'hB0, 3'd0);
    expect_byte(8'hB3, 3'd3);
    wait_done("post-reset priority", 300);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
